// File: rtl/imm_pkg.sv
// Shared types for the immediate-generation stage: format selects and
// skid-buffer occupancy states.
package imm_pkg;

  // Width of the raw instruction word fed to the extractor.
  localparam int unsigned INSTR_WIDTH = 32;

  // Width of the format select bus; codes 8..15 are reserved.
  localparam int unsigned IMM_SRC_WIDTH = 4;

  // Internal working width of the extractor before truncation to XLEN.
  localparam int unsigned IMM_WORK_WIDTH = 64;

  typedef enum logic [IMM_SRC_WIDTH-1:0] {
    IMM_I     = 4'd0,
    IMM_S     = 4'd1,
    IMM_B     = 4'd2,
    IMM_U     = 4'd3,
    IMM_J     = 4'd4,
    IMM_CSR   = 4'd5,
    IMM_SHAMT = 4'd6,
    IMM_ZERO  = 4'd7
  } imm_src_e;

  // Number of entries held: main output register plus one skid entry.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate extractor. Every format is built at 64 bits and
// truncated to XLEN, so the same expressions serve both XLEN settings.
module imm_extract
  import imm_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [INSTR_WIDTH-1:0]   instr,
  input  logic [IMM_SRC_WIDTH-1:0] imm_src,
  output logic [XLEN-1:0]          imm,
  output logic                     illegal
);

  logic                      sign;
  logic [IMM_WORK_WIDTH-1:0] imm64;

  assign sign = instr[31];

  // Opcode bits never contribute to any immediate.
  logic unused_opcode;
  assign unused_opcode = ^instr[6:0];

  // Format decode; reserved selects yield zero and flag illegal.
  always_comb begin
    imm64   = '0;
    illegal = 1'b0;
    case (imm_src)
      IMM_I:     imm64 = {{52{sign}}, instr[31:20]};
      IMM_S:     imm64 = {{52{sign}}, instr[31:25], instr[11:7]};
      IMM_B:     imm64 = {{51{sign}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:     imm64 = {{32{sign}}, instr[31:12], 12'b0};
      IMM_J:     imm64 = {{43{sign}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      IMM_CSR:   imm64 = {59'b0, instr[19:15]};
      IMM_SHAMT: begin
        if (XLEN == 64) begin
          imm64 = {58'b0, instr[25:20]};
        end else begin
          // RV32 shift amounts are 5 bits; bit 25 set is out of range.
          imm64   = {59'b0, instr[24:20]};
          illegal = instr[25];
        end
      end
      IMM_ZERO:  imm64 = '0;
      default: begin
        imm64   = '0;
        illegal = 1'b1;
      end
    endcase
  end

  assign imm = imm64[XLEN-1:0];

  if (XLEN < IMM_WORK_WIDTH) begin : g_unused_hi
    logic unused_hi;
    assign unused_hi = ^imm64[IMM_WORK_WIDTH-1:XLEN];
  end

endmodule

// File: rtl/imm_decode_pipe.sv
// Registered immediate-generation stage. Immediates are extracted on the
// input side, so both the main and skid entries hold final results. A
// 2-entry skid keeps full throughput while in_ready stays registered.
module imm_decode_pipe
  import imm_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned TAG_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [INSTR_WIDTH-1:0]   instr,
  input  logic [IMM_SRC_WIDTH-1:0] imm_src,
  input  logic [TAG_WIDTH-1:0]     in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_imm,
  output logic                     out_illegal,
  output logic [TAG_WIDTH-1:0]     out_tag
);

  if (!(XLEN == 32 || XLEN == 64)) begin : g_xlen_check
    $error("imm_decode_pipe: XLEN must be 32 or 64");
  end

  logic [XLEN-1:0] ext_imm;
  logic            ext_illegal;

  imm_extract #(
    .XLEN(XLEN)
  ) u_extract (
    .instr  (instr),
    .imm_src(imm_src),
    .imm    (ext_imm),
    .illegal(ext_illegal)
  );

  occ_e occ_q, occ_d;
  logic in_ready_q;

  logic [XLEN-1:0]      main_imm_q, skid_imm_q;
  logic                 main_illegal_q, skid_illegal_q;
  logic [TAG_WIDTH-1:0] main_tag_q, skid_tag_q;

  logic accept;
  logic drain;
  logic load_main_in;
  logic load_main_skid;
  logic load_skid;

  // in_ready_q is set during reset so the stage accepts on the first free
  // cycle; gating with rst holds it low while reset is asserted.
  assign in_ready  = in_ready_q & ~rst;
  assign out_valid = (occ_q != OCC_EMPTY);
  assign accept    = in_valid & in_ready & ~flush;
  assign drain     = out_valid & out_ready;

  // Occupancy next-state and entry load selects; flush overrides everything.
  always_comb begin
    occ_d          = occ_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      occ_d = OCC_EMPTY;
    end else begin
      case (occ_q)
        OCC_EMPTY: begin
          if (accept) begin
            occ_d        = OCC_ONE;
            load_main_in = 1'b1;
          end
        end
        OCC_ONE: begin
          if (accept && drain) begin
            load_main_in = 1'b1;
          end else if (accept) begin
            occ_d     = OCC_TWO;
            load_skid = 1'b1;
          end else if (drain) begin
            occ_d = OCC_EMPTY;
          end
        end
        OCC_TWO: begin
          // in_ready is low here, so only a drain can occur.
          if (drain) begin
            occ_d          = OCC_ONE;
            load_main_skid = 1'b1;
          end
        end
        default: occ_d = OCC_EMPTY;
      endcase
    end
  end

  // Occupancy state and registered in_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q      <= OCC_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      occ_q      <= occ_d;
      in_ready_q <= (occ_d != OCC_TWO);
    end
  end

  // Main (output) entry: loads from the extractor or promotes the skid.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_imm_q     <= '0;
      main_illegal_q <= 1'b0;
      main_tag_q     <= '0;
    end else if (load_main_in) begin
      main_imm_q     <= ext_imm;
      main_illegal_q <= ext_illegal;
      main_tag_q     <= in_tag;
    end else if (load_main_skid) begin
      main_imm_q     <= skid_imm_q;
      main_illegal_q <= skid_illegal_q;
      main_tag_q     <= skid_tag_q;
    end
  end

  // Skid entry: captures an accept that arrives while the output stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      skid_imm_q     <= '0;
      skid_illegal_q <= 1'b0;
      skid_tag_q     <= '0;
    end else if (load_skid) begin
      skid_imm_q     <= ext_imm;
      skid_illegal_q <= ext_illegal;
      skid_tag_q     <= in_tag;
    end
  end

  assign out_imm     = main_imm_q;
  assign out_illegal = main_illegal_q;
  assign out_tag     = main_tag_q;

endmodule

// File: tb/tb_imm_decode_pipe.sv
// Bench for imm_decode_pipe: XLEN=32 and XLEN=64 instances share stimulus
// and are checked against an arithmetic reference model and a FIFO scoreboard.
module tb_imm_decode_pipe;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] instr;
  logic [3:0]  imm_src;
  logic [4:0]  in_tag;

  logic        ir32, ov32, ill32, ir64, ov64, ill64;
  logic [31:0] imm32;
  logic [63:0] imm64;
  logic [4:0]  tag32, tag64;

  always #5 clk = ~clk;

  imm_decode_pipe #(.XLEN(32), .TAG_WIDTH(5)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir32),
    .instr(instr), .imm_src(imm_src), .in_tag(in_tag), .out_valid(ov32),
    .out_ready(out_ready), .out_imm(imm32), .out_illegal(ill32), .out_tag(tag32)
  );

  imm_decode_pipe #(.XLEN(64), .TAG_WIDTH(5)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir64),
    .instr(instr), .imm_src(imm_src), .in_tag(in_tag), .out_valid(ov64),
    .out_ready(out_ready), .out_imm(imm64), .out_illegal(ill64), .out_tag(tag64)
  );

  typedef struct {
    logic [63:0] i32;
    logic [63:0] i64;
    logic        l32;
    logic        l64;
    logic [4:0]  tag;
  } ent_t;

  ent_t q[$];
  logic zero_exp;
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Two's-complement sign extension of the low n bits.
  function automatic logic [63:0] sext(input logic [63:0] v, input int n);
    logic [63:0] m;
    m = 64'd1 << (n - 1);
    v = v & ((m << 1) - 64'd1);
    return (v ^ m) - m;
  endfunction

  task automatic ref_ext(input logic [31:0] ins, input logic [3:0] src, input int xlen,
                         output logic [63:0] imm, output logic ill);
    logic [63:0] w;
    w   = {32'b0, ins};
    ill = 1'b0;
    case (src)
      4'd0: imm = sext(w >> 20, 12);
      4'd1: imm = sext(((w >> 25) << 5) | ((w >> 7) & 64'd31), 12);
      4'd2: imm = sext(((w >> 31) << 12) | (((w >> 7) & 64'd1) << 11)
                       | (((w >> 25) & 64'd63) << 5) | (((w >> 8) & 64'd15) << 1), 13);
      4'd3: imm = sext(w & 64'hFFFF_F000, 32);
      4'd4: imm = sext(((w >> 31) << 20) | (((w >> 12) & 64'd255) << 12)
                       | (((w >> 20) & 64'd1) << 11) | (((w >> 21) & 64'd1023) << 1), 21);
      4'd5: imm = (w >> 15) & 64'd31;
      4'd6: begin
        imm = (xlen == 64) ? ((w >> 20) & 64'd63) : ((w >> 20) & 64'd31);
        ill = (xlen == 32) && (((w >> 25) & 64'd1) == 64'd1);
      end
      4'd7: imm = 64'd0;
      default: begin
        imm = 64'd0;
        ill = 1'b1;
      end
    endcase
    if (xlen == 32) imm = imm & 64'hFFFF_FFFF;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [3:0] src,
                       input logic [4:0] tg, input logic ordy, input logic fl);
    in_valid  = v;
    instr     = ins;
    imm_src   = src;
    in_tag    = tg;
    out_ready = ordy;
    flush     = fl;
  endtask

  // One clock: check outputs at the falling edge, then advance the model.
  task automatic cycle();
    logic exp_ir, exp_ov, acc, drn;
    ent_t e;
    @(negedge clk);
    exp_ir = !rst && (q.size() < 2);
    exp_ov = (q.size() > 0);
    chk("in_ready32", ir32, exp_ir);
    chk("in_ready64", ir64, exp_ir);
    chk("out_valid32", ov32, exp_ov);
    chk("out_valid64", ov64, exp_ov);
    if (exp_ov) begin
      chk("imm32", imm32, q[0].i32);
      chk("imm64", imm64, q[0].i64);
      chk("illegal32", ill32, q[0].l32);
      chk("illegal64", ill64, q[0].l64);
      chk("tag32", tag32, q[0].tag);
      chk("tag64", tag64, q[0].tag);
    end else if (zero_exp) begin
      chk("rst_imm32", imm32, 64'd0);
      chk("rst_imm64", imm64, 64'd0);
      chk("rst_ill", {ill32, ill64}, 64'd0);
      chk("rst_tag", {tag32, tag64}, 64'd0);
    end
    acc = in_valid && exp_ir && !flush;
    drn = exp_ov && out_ready;
    ref_ext(instr, imm_src, 32, e.i32, e.l32);
    ref_ext(instr, imm_src, 64, e.i64, e.l64);
    e.tag = in_tag;
    @(posedge clk);
    if (rst || flush) begin
      q.delete();
      if (rst) zero_exp = 1'b1;
    end else begin
      if (drn) void'(q.pop_front());
      if (acc) begin
        q.push_back(e);
        zero_exp = 1'b0;
      end
    end
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [3:0] srcs[4];
    srcs = '{4'd1, 4'd0, 4'd3, 4'd4};
    rst = 1'b1;
    zero_exp = 1'b1;
    drive(1'b0, 32'd0, 4'd0, 5'd0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    // Inputs during reset are ignored.
    drive(1'b1, $urandom, 4'd0, 5'd9, 1'b1, 1'b0);
    repeat (2) cycle();
    rst = 1'b0;

    drive(1'b1, 32'hFFF0_0093, 4'd0, 5'd1, 1'b1, 1'b0);
    cycle();
    chk("lit_i_imm32", imm32, 64'hFFFF_FFFF);
    chk("lit_i_valid", ov32, 1'b1);
    drive(1'b1, 32'hFE00_0EE3, 4'd2, 5'd2, 1'b1, 1'b0);
    cycle();
    chk("lit_b_imm32", imm32, 64'hFFFF_FFFC);
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, $urandom, srcs[k], 5'(k + 3), 1'b1, 1'b0);
      cycle();
    end
    drive(1'b1, 32'h8000_00B7, 4'd3, 5'd7, 1'b1, 1'b0);
    cycle();
    chk("lit_u_imm64", imm64, 64'hFFFF_FFFF_8000_0000);
    drive(1'b1, 32'h8000_006F, 4'd4, 5'd8, 1'b1, 1'b0);
    cycle();
    chk("lit_j_imm64", imm64, 64'hFFFF_FFFF_FFF0_0000);
    drive(1'b0, 32'd0, 4'd0, 5'd0, 1'b1, 1'b0);
    repeat (2) cycle();

    // Backpressure: tags 1,2 fill both entries, tag 3 waits.
    drive(1'b1, $urandom, 4'd0, 5'd1, 1'b0, 1'b0);
    cycle();
    drive(1'b1, $urandom, 4'd1, 5'd2, 1'b0, 1'b0);
    cycle();
    chk("bp_in_ready_low", ir32, 1'b0);
    chk("bp_hold_tag1", tag32, 5'd1);
    drive(1'b1, $urandom, 4'd2, 5'd3, 1'b0, 1'b0);
    cycle();
    chk("bp_still_tag1", tag32, 5'd1);
    out_ready = 1'b1;
    cycle();
    chk("bp_tag2", tag32, 5'd2);
    cycle();
    chk("bp_tag3", tag32, 5'd3);
    in_valid = 1'b0;
    cycle();
    chk("bp_empty", ov32, 1'b0);

    // Flush while full; the input offered alongside flush must vanish.
    drive(1'b1, $urandom, 4'd0, 5'd10, 1'b0, 1'b0);
    repeat (2) cycle();
    drive(1'b1, $urandom, 4'd0, 5'd17, 1'b0, 1'b1);
    cycle();
    chk("flush_out_valid", ov32, 1'b0);
    chk("flush_in_ready", ir32, 1'b1);
    drive(1'b0, 32'd0, 4'd0, 5'd0, 1'b1, 1'b0);
    repeat (2) cycle();

    // Reset while full.
    drive(1'b1, $urandom, 4'd4, 5'd20, 1'b0, 1'b0);
    repeat (2) cycle();
    rst = 1'b1;
    cycle();
    chk("rst_in_ready_low", ir64, 1'b0);
    chk("rst_out_valid", ov64, 1'b0);
    chk("rst_tag_zero", tag64, 5'd0);
    rst = 1'b0;
    in_valid = 1'b0;
    cycle();

    // Reserved format, RV32 shamt range, CSR zimm.
    drive(1'b1, $urandom, 4'hA, 5'd4, 1'b1, 1'b0);
    cycle();
    chk("lit_reserved_ill", ill32, 1'b1);
    chk("lit_reserved_imm", imm64, 64'd0);
    drive(1'b1, $urandom | 32'h0200_0000, 4'd6, 5'd5, 1'b1, 1'b0);
    cycle();
    chk("lit_shamt32_ill", ill32, 1'b1);
    chk("lit_shamt64_ok", ill64, 1'b0);
    drive(1'b1, $urandom | 32'h000F_8000, 4'd5, 5'd6, 1'b1, 1'b0);
    cycle();
    chk("lit_csr_imm", imm32, 64'h1F);
    chk("lit_csr_ill", ill32, 1'b0);

    // Random traffic with backpressure and occasional flush.
    for (int n = 0; n < 400; n++) begin
      drive(($urandom % 4) != 0, $urandom, 4'($urandom_range(0, 15)), 5'($urandom),
            ($urandom % 3) != 0, ($urandom % 32) == 0);
      cycle();
    end

    drive(1'b0, 32'd0, 4'd0, 5'd0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cycle();
    chk("final_empty", ov32, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
